// File: rtl/mem_wait_if.sv
// Request/ready bus between an initiator and mem_wait_responder.
// The initiator raises r_enable/w_enable with addr/w_data and holds them until ready; ready is a one-cycle pulse.
interface mem_wait_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic [ADDR_W-1:0] addr;
  logic              r_enable;
  logic              w_enable;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] r_data;
  logic              ready;
  logic              err;

  modport master (
    output addr, r_enable, w_enable, w_data,
    input  r_data, ready, err
  );

  modport slave (
    input  addr, r_enable, w_enable, w_data,
    output r_data, ready, err
  );
endinterface

// File: rtl/mem_wait_responder.sv
// Single-outstanding memory responder with programmable wait states (IDLE -> WAIT -> RESP).
// Define MEM_WAIT_LFSR_EN to add a pseudo-random 0..3 extra wait cycles from an 8-bit LFSR.
module mem_wait_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic       clk,
  input  logic       reset,
  mem_wait_if.slave  bus,
  output logic [1:0] o_dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [4:0] BASE_WAIT = (WAIT_CYCLES > 15) ? 5'd15 : 5'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wr;
  logic              r_both;
  logic              r_ready;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_req;
  logic [3:0]        w_wait_len;
  logic              w_complete;
  logic [ADDR_W-1:0] w_t_addr;
  logic [DATA_W-1:0] w_t_wdata;
  logic              w_t_wr;
  logic              w_t_both;
  logic              w_in_range;
  logic [IDX_W-1:0]  w_idx;
  logic              w_mem_we;
  logic              w_unused_bits;

`ifdef MEM_WAIT_LFSR_EN
  logic [7:0] r_lfsr;
  logic [4:0] w_sum;

  // x^8+x^6+x^5+x^4+1, stepped once per accepted request
  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= 8'hA5;
    else if (r_state == S_IDLE && w_req)
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  end

  always_comb begin
    w_sum      = BASE_WAIT + {3'b000, r_lfsr[1:0]};
    w_wait_len = (w_sum > 5'd15) ? 4'd15 : w_sum[3:0];
  end
`else
  always_comb begin
    w_wait_len = BASE_WAIT[3:0];
  end
`endif

  assign w_req = bus.r_enable | bus.w_enable;

  // With zero wait states the transaction completes on its accept edge, so use the live inputs.
  always_comb begin
    w_t_addr  = r_addr;
    w_t_wdata = r_wdata;
    w_t_wr    = r_wr;
    w_t_both  = r_both;
    if (r_state == S_IDLE) begin
      w_t_addr  = bus.addr;
      w_t_wdata = bus.w_data;
      w_t_wr    = bus.w_enable;
      w_t_both  = bus.r_enable & bus.w_enable;
    end
  end

  assign w_complete = ((r_state == S_IDLE) && w_req && (w_wait_len == 4'd0)) ||
                      ((r_state == S_WAIT) && (r_cnt == 4'd1));
  assign w_in_range    = (w_t_addr[ADDR_W-1:IDX_W+2] == '0);
  assign w_idx         = w_t_addr[IDX_W+1:2];
  assign w_mem_we      = w_complete && w_t_wr && w_in_range && !reset;
  assign w_unused_bits = ^w_t_addr[1:0];

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_idx] <= w_t_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wr    <= 1'b0;
      r_both  <= 1'b0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr  <= bus.addr;
            r_wdata <= bus.w_data;
            r_wr    <= bus.w_enable;
            r_both  <= bus.r_enable & bus.w_enable;
            r_cnt   <= w_wait_len;
            r_state <= (w_wait_len == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) r_state <= S_RESP;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      // ready/err/r_data are loaded on the edge that enters RESP so they are visible during it
      if (w_complete) begin
        r_ready <= 1'b1;
        r_err   <= w_t_both | !w_in_range;
        if (!w_t_wr) r_rdata <= w_in_range ? r_mem[w_idx] : '0;
      end
    end
  end

  assign bus.ready   = r_ready;
  assign bus.err     = r_err;
  assign bus.r_data  = r_rdata;
  assign o_dbg_state = r_state;

endmodule
